// File: rtl/switch_ingress_fifo_if.sv
// Handshake bundle between a port receiver / switch scheduler and one ingress FIFO.
// SWITCH_INGRESS_DROP_COUNT_EN adds the drop_count signal to the bundle.
interface switch_ingress_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic             wrreq;
   logic [WIDTH-1:0] wrdata;
   logic             rdreq;
   logic [WIDTH-1:0] q;
   logic             empty;
   logic             full;
   logic [AW:0]      usedw;
   logic             overflow;
`ifdef SWITCH_INGRESS_DROP_COUNT_EN
   logic [15:0]      drop_count;

   modport master (output wrreq, wrdata, rdreq,
                   input  q, empty, full, usedw, overflow, drop_count);
   modport slave  (input  wrreq, wrdata, rdreq,
                   output q, empty, full, usedw, overflow, drop_count);
`else
   modport master (output wrreq, wrdata, rdreq,
                   input  q, empty, full, usedw, overflow);
   modport slave  (input  wrreq, wrdata, rdreq,
                   output q, empty, full, usedw, overflow);
`endif
endinterface

// File: rtl/switch_ingress_fifo.sv
// Per-port show-ahead ingress queue feeding the switch scheduler.
// Optional saturating drop counter enabled by SWITCH_INGRESS_DROP_COUNT_EN.
module switch_ingress_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input logic                 clk,
   input logic                 reset,
   switch_ingress_fifo_if.slave bus
);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
         $error("switch_ingress_fifo: DEPTH must be a power of 2 and >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             wr_en;
   logic             rd_en;
   logic             overflow;

   // Flags come straight from the registered pointers, so they can never disagree with usedw.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_en = bus.wrreq && !full;
   assign rd_en = bus.rdreq && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; q masks unwritten entries by forcing zero while empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.wrdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  overflow <= 1'b0;
      else if (bus.wrreq && full) overflow <= 1'b1;
   end

`ifdef SWITCH_INGRESS_DROP_COUNT_EN
   logic [15:0] drop_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         drop_count <= '0;
      else if (bus.wrreq && full && drop_count != 16'hFFFF)
         drop_count <= drop_count + 16'd1;
   end

   assign bus.drop_count = drop_count;
`endif

   assign bus.q        = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.usedw    = wr_ptr - rd_ptr;
   assign bus.overflow = overflow;
endmodule

// File: tb/tb_switch_ingress_fifo.sv
// Self-checking bench for switch_ingress_fifo: table vectors, corner sequences, random vs queue model.
module tb_switch_ingress_fifo;
   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset;

   switch_ingress_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   switch_ingress_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [7:0] mdl[$];
   logic       m_ovf;
   int         m_drop;

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       rd;
      logic       e_empty;
      logic [4:0] e_usedw;
      logic [7:0] e_q;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      mdl.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input logic wr, input logic [7:0] d, input logic rd);
      logic m_full, m_empty;
      m_full  = (mdl.size() == DEPTH);
      m_empty = (mdl.size() == 0);
      bus.wrreq  = wr;
      bus.wrdata = d;
      bus.rdreq  = rd;
      @(posedge clk);
      if (rd && !m_empty) void'(mdl.pop_front());
      if (wr && !m_full) mdl.push_back(d);
      else if (wr) begin
         m_ovf = 1'b1;
         if (m_drop < 65535) m_drop++;
      end
      @(negedge clk);
      bus.wrreq = 1'b0;
      bus.rdreq = 1'b0;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".empty"},    bus.empty,    (mdl.size() == 0));
      chk({tag, ".full"},     bus.full,     (mdl.size() == DEPTH));
      chk({tag, ".usedw"},    bus.usedw,    mdl.size());
      chk({tag, ".q"},        bus.q,        (mdl.size() == 0) ? 8'h00 : mdl[0]);
      chk({tag, ".overflow"}, bus.overflow, m_ovf);
`ifdef SWITCH_INGRESS_DROP_COUNT_EN
      chk({tag, ".drop"},     bus.drop_count, m_drop);
`endif
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".empty"},    bus.empty,    1'b1);
      chk({tag, ".full"},     bus.full,     1'b0);
      chk({tag, ".usedw"},    bus.usedw,    0);
      chk({tag, ".q"},        bus.q,        8'h00);
      chk({tag, ".overflow"}, bus.overflow, 1'b0);
`ifdef SWITCH_INGRESS_DROP_COUNT_EN
      chk({tag, ".drop"},     bus.drop_count, 0);
`endif
   endtask

   initial begin
      tbl[0] = '{1'b1, 8'h03, 1'b0, 1'b0, 5'd1, 8'h03};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 8'h03};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h00};
      tbl[3] = '{1'b1, 8'h42, 1'b0, 1'b0, 5'd1, 8'h42};
      tbl[4] = '{1'b1, 8'h77, 1'b1, 1'b0, 5'd1, 8'h77};
      tbl[5] = '{1'b1, 8'h99, 1'b1, 1'b0, 5'd1, 8'h99};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h00};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h00};
      tbl[8] = '{1'b1, 8'h5A, 1'b1, 1'b0, 5'd1, 8'h5A};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h00};

      bus.wrreq  = 1'b0;
      bus.wrdata = 8'h00;
      bus.rdreq  = 1'b0;
      reset      = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk_reset_vals("reset_idle");

      // Table vectors: single words, pops, simultaneous ops at occupancy 0 and 1.
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].wr, tbl[i].d, tbl[i].rd);
         chk($sformatf("tbl%0d.empty", i), bus.empty, tbl[i].e_empty);
         chk($sformatf("tbl%0d.usedw", i), bus.usedw, tbl[i].e_usedw);
         chk($sformatf("tbl%0d.q", i),     bus.q,     tbl[i].e_q);
         chk($sformatf("tbl%0d.full", i),  bus.full,  1'b0);
      end

      // Fill to full, one rejected write, drain in order.
      for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
      chk("fill.full", bus.full, 1'b1);
      chk("fill.usedw", bus.usedw, 16);
      chk("fill.overflow", bus.overflow, 1'b0);
      step(1'b1, 8'hAA, 1'b0);
      chk("ovf.full", bus.full, 1'b1);
      chk("ovf.usedw", bus.usedw, 16);
      chk("ovf.overflow", bus.overflow, 1'b1);
`ifdef SWITCH_INGRESS_DROP_COUNT_EN
      chk("ovf.drop", bus.drop_count, 1);
`endif
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d.q", i), bus.q, 8'h10 + 8'(i));
         step(1'b0, 8'h00, 1'b1);
      end
      chk("drain.empty", bus.empty, 1'b1);
      chk("drain.q", bus.q, 8'h00);
      chk("drain.overflow_sticky", bus.overflow, 1'b1);

      // Simultaneous read/write while full: read wins, write dropped.
      for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
      step(1'b1, 8'h55, 1'b1);
      chk("fullrw.usedw", bus.usedw, 15);
      chk("fullrw.full", bus.full, 1'b0);
      chk("fullrw.overflow", bus.overflow, 1'b1);
`ifdef SWITCH_INGRESS_DROP_COUNT_EN
      chk("fullrw.drop", bus.drop_count, 2);
`endif
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("fullrw_drain%0d.q", i), bus.q, 8'h21 + 8'(i));
         step(1'b0, 8'h00, 1'b1);
      end
      chk("fullrw_drain.empty", bus.empty, 1'b1);

      // Steady streaming at occupancy 3 across several pointer wraps.
      for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("wrap%0d.q", i), bus.q, 8'h30 + 8'(i));
         step(1'b1, 8'h33 + 8'(i), 1'b1);
         chk($sformatf("wrap%0d.usedw", i), bus.usedw, 3);
      end
      while (mdl.size() != 0) begin
         step(1'b0, 8'h00, 1'b1);
         chk_model("wrap_drain");
      end

      // Asynchronous reset mid-stream at occupancy 9.
      for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
      chk("pre_rst.usedw", bus.usedw, 9);
      reset = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      #2;
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      step(1'b1, 8'hC3, 1'b0);
      chk("post_rst.q", bus.q, 8'hC3);
      chk("post_rst.usedw", bus.usedw, 1);
      step(1'b0, 8'h00, 1'b1);
      chk("post_rst.empty", bus.empty, 1'b1);

      // Random traffic in write-heavy, balanced and read-heavy phases against the queue model.
      for (int ph = 0; ph < 3; ph++) begin
         int wp, rp;
         wp = (ph == 0) ? 80 : (ph == 1) ? 50 : 20;
         rp = 100 - wp;
         for (int c = 0; c < 150; c++) begin
            step(($urandom_range(99) < wp), 8'($urandom_range(255)), ($urandom_range(99) < rp));
            chk_model($sformatf("rand_p%0d_c%0d", ph, c));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
